// File: rtl/flappy_game_pkg.sv
// Shared types and defaults for the flappy game sequencer.
package flappy_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_SCORE_W = 16;

endpackage

// File: rtl/game_sequencer_if.sv
// Control/status bundle between input decode, the game sequencer and the
// motion/score/overlay logic. master drives the requests, slave is the sequencer.
interface game_sequencer_if #(
    parameter int unsigned SCORE_W = flappy_game_pkg::DEFAULT_SCORE_W
);
    import flappy_game_pkg::*;

    logic               flap_req;
    logic               pause_req;
    logic               help_req;
    logic               collision;
    logic               score_inc;
    state_t             state;
    logic               game_tick;
    logic               flap_pulse;
    logic               world_rst;
    logic               show_help;
    logic               show_pause;
    logic               show_over;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] best_score;

    modport master (
        output flap_req, pause_req, help_req, collision, score_inc,
        input  state, game_tick, flap_pulse, world_rst,
               show_help, show_pause, show_over, score, best_score
    );

    modport slave (
        input  flap_req, pause_req, help_req, collision, score_inc,
        output state, game_tick, flap_pulse, world_rst,
               show_help, show_pause, show_over, score, best_score
    );

endinterface

// File: rtl/game_sequencer_tick_prescaler.sv
// Free-running divider: raw_tick is high for one cycle every TICK_DIV cycles.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic system_clk,
    input  logic reset,
    output logic raw_tick
);
    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign raw_tick = (cnt == CNT_W'(TICK_DIV - 1));

    // Count 0..TICK_DIV-1 and wrap, independent of game state.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (raw_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-state controller: IDLE -> PLAY <-> PAUSE, PLAY -> OVER -> IDLE.
// Produces gated game tick, restart pulse, overlay selects and score.
// Optional feature macro: BEST_SCORE_EN (tracks best score across games).
module game_sequencer
    import flappy_game_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 500000,
    parameter int unsigned HOLDOFF_TICKS = 50,
    parameter int unsigned SCORE_W       = DEFAULT_SCORE_W
) (
    input  logic               system_clk,
    input  logic               reset,
    game_sequencer_if.slave    bus
);
    localparam int unsigned HOLD_W = $clog2(HOLDOFF_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLDOFF_TICKS);

    state_t             cur_state;
    logic               raw_tick;
    logic               flap_q;
    logic               flap_edge;
    logic [HOLD_W-1:0]  holdoff;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] score_plus;
    logic [SCORE_W-1:0] score_next;
    logic               game_tick;
    logic               flap_pulse;
    logic               world_rst;
    logic               show_help;
    logic               show_pause;
    logic               show_over;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .system_clk (system_clk),
        .reset      (reset),
        .raw_tick   (raw_tick)
    );

    assign flap_edge  = bus.flap_req & ~flap_q;
    assign score_plus = (score == '1) ? score : score + SCORE_W'(1);
    assign score_next = bus.score_inc ? score_plus : score;

    // Sequencer FSM with holdoff, score and all registered control outputs.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            cur_state  <= ST_IDLE;
            flap_q     <= 1'b0;
            holdoff    <= '0;
            score      <= '0;
            game_tick  <= 1'b0;
            flap_pulse <= 1'b0;
            world_rst  <= 1'b0;
            show_help  <= 1'b0;
            show_pause <= 1'b0;
            show_over  <= 1'b0;
        end else begin
            flap_q     <= bus.flap_req;
            game_tick  <= raw_tick && (cur_state == ST_PLAY);
            flap_pulse <= 1'b0;
            world_rst  <= 1'b0;
            case (cur_state)
                ST_IDLE: begin
                    show_help <= bus.help_req;
                    if (flap_edge && !bus.help_req) begin
                        cur_state <= ST_PLAY;
                        world_rst <= 1'b1;
                        score     <= '0;
                        show_help <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    // Scoring is independent of the transition priority below.
                    score <= score_next;
                    if (bus.collision) begin
                        cur_state <= ST_OVER;
                        holdoff   <= '0;
                        show_over <= 1'b1;
                    end else if (bus.pause_req) begin
                        cur_state  <= ST_PAUSE;
                        show_pause <= 1'b1;
                    end else if (flap_edge) begin
                        flap_pulse <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (!bus.pause_req) begin
                        cur_state  <= ST_PLAY;
                        show_pause <= 1'b0;
                    end
                end
                ST_OVER: begin
                    if (raw_tick && (holdoff != HOLD_MAX)) begin
                        holdoff <= holdoff + HOLD_W'(1);
                    end
                    // Edges before the holdoff expires are simply dropped.
                    if (flap_edge && (holdoff == HOLD_MAX)) begin
                        cur_state <= ST_IDLE;
                        world_rst <= 1'b1;
                        score     <= '0;
                        show_over <= 1'b0;
                        show_help <= bus.help_req;
                    end
                end
                default: cur_state <= ST_IDLE;
            endcase
        end
    end

`ifdef BEST_SCORE_EN
    logic [SCORE_W-1:0] best_score;

    // Capture the final score of each game if it beats the stored best.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            best_score <= '0;
        end else if ((cur_state == ST_PLAY) && bus.collision && (score_next > best_score)) begin
            best_score <= score_next;
        end
    end

    assign bus.best_score = best_score;
`else
    assign bus.best_score = '0;
`endif

    assign bus.state      = cur_state;
    assign bus.game_tick  = game_tick;
    assign bus.flap_pulse = flap_pulse;
    assign bus.world_rst  = world_rst;
    assign bus.show_help  = show_help;
    assign bus.show_pause = show_pause;
    assign bus.show_over  = show_over;
    assign bus.score      = score;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with TICK_DIV=4, HOLDOFF_TICKS=3, SCORE_W=4.
// Expected best_score depends on whether BEST_SCORE_EN is defined for the build.
module tb_game_sequencer;
    import flappy_game_pkg::*;

    localparam int unsigned TD = 4;
    localparam int unsigned HT = 3;
    localparam int unsigned SW = 4;
`ifdef BEST_SCORE_EN
    localparam bit BEST_ON = 1'b1;
`else
    localparam bit BEST_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned pcnt     = 0;
    bit          last_raw = 1'b0;
    bit          in_over  = 1'b0;
    int unsigned hold     = 0;

    game_sequencer_if #(.SCORE_W(SW)) bus ();

    game_sequencer #(
        .TICK_DIV      (TD),
        .HOLDOFF_TICKS (HT),
        .SCORE_W       (SW)
    ) dut (
        .system_clk (clk),
        .reset      (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; tracks the prescaler phase and OVER holdoff in the bench.
    task automatic step();
        @(posedge clk);
        last_raw = !rst && (pcnt == TD - 1);
        if (rst) pcnt = 0;
        else     pcnt = last_raw ? 0 : pcnt + 1;
        if (in_over && last_raw && hold < HT) hold++;
        #1;
    endtask

    task automatic pulse_score(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            bus.score_inc = 1'b1;
            step();
            bus.score_inc = 1'b0;
            step();
        end
    endtask

    task automatic collide();
        bus.collision = 1'b1;
        step();
        bus.collision = 1'b0;
        in_over = 1'b1;
        hold    = 0;
    endtask

    task automatic to_idle();
        for (int k = 0; k < 64 && hold < HT; k++) step();
        if (hold < HT) chk("holdoff_timeout", hold, HT);
        chk("over_no_queue", bus.state, ST_OVER);
        bus.flap_req = 1'b1;
        step();
        in_over = 1'b0;
        chk("restart_state", bus.state, ST_IDLE);
        chk("restart_wrst", bus.world_rst, 1);
        chk("restart_score", bus.score, 0);
        chk("restart_over", bus.show_over, 0);
        bus.flap_req = 1'b0;
        step();
    endtask

    task automatic to_play();
        bus.flap_req = 1'b1;
        step();
        chk("start_state", bus.state, ST_PLAY);
        bus.flap_req = 1'b0;
        step();
    endtask

    initial begin
        int unsigned ticks;
        int unsigned pulses;

        bus.flap_req  = 1'b0;
        bus.pause_req = 1'b0;
        bus.help_req  = 1'b0;
        bus.collision = 1'b0;
        bus.score_inc = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk("rst_state", bus.state, ST_IDLE);
        chk("rst_outs", {bus.game_tick, bus.flap_pulse, bus.world_rst,
                         bus.show_help, bus.show_pause, bus.show_over}, 0);
        chk("rst_score", bus.score, 0);
        chk("rst_best", bus.best_score, 0);
        rst = 1'b0;

        ticks = 0;
        for (int i = 0; i < 8; i++) begin step(); ticks += bus.game_tick; end
        chk("idle_no_tick", ticks, 0);

        // Help overlay suppresses start.
        bus.help_req = 1'b1;
        step();
        chk("help_show", bus.show_help, 1);
        bus.flap_req = 1'b1;
        step();
        chk("help_flap_state", bus.state, ST_IDLE);
        chk("help_flap_wrst", bus.world_rst, 0);
        bus.flap_req = 1'b0;
        bus.help_req = 1'b0;
        step();
        chk("help_clear", bus.show_help, 0);

        // Start a game.
        bus.flap_req = 1'b1;
        step();
        chk("start_state", bus.state, ST_PLAY);
        chk("start_wrst", bus.world_rst, 1);
        chk("start_score", bus.score, 0);
        step();
        chk("wrst_one_cycle", bus.world_rst, 0);
        chk("held_flap_no_pulse", bus.flap_pulse, 0);
        bus.flap_req = 1'b0;
        step();

        ticks = 0;
        for (int i = 0; i < 16; i++) begin step(); ticks += bus.game_tick; end
        chk("play_ticks_16cyc", ticks, 4);

        bus.flap_req = 1'b1;
        step();
        chk("flap_pulse", bus.flap_pulse, 1);
        bus.flap_req = 1'b0;
        step();
        chk("flap_pulse_end", bus.flap_pulse, 0);

        pulse_score(5);
        chk("score5", bus.score, 5);

        // Pause ignores collision, flap and score.
        bus.pause_req = 1'b1;
        step();
        chk("pause_state", bus.state, ST_PAUSE);
        chk("pause_show", bus.show_pause, 1);
        ticks = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            bus.collision = (i % 5 == 0);
            bus.flap_req  = i[0];
            bus.score_inc = 1'b1;
            step();
            ticks  += bus.game_tick;
            pulses += bus.flap_pulse;
        end
        chk("pause_hold", bus.state, ST_PAUSE);
        chk("pause_ticks", ticks, 0);
        chk("pause_pulses", pulses, 0);
        chk("pause_score", bus.score, 5);
        bus.collision = 1'b0;
        bus.flap_req  = 1'b0;
        bus.score_inc = 1'b0;
        bus.pause_req = 1'b0;
        step();
        chk("unpause_state", bus.state, ST_PLAY);
        chk("unpause_show", bus.show_pause, 0);
        chk("unpause_score", bus.score, 5);

        // Collision with coincident score pulse.
        bus.score_inc = 1'b1;
        collide();
        bus.score_inc = 1'b0;
        chk("over_state", bus.state, ST_OVER);
        chk("over_score", bus.score, 6);
        chk("over_show", bus.show_over, 1);
        chk("best_g1", bus.best_score, BEST_ON ? 6 : 0);

        // A flap one raw tick short of the holdoff is dropped.
        for (int k = 0; k < 64 && hold < HT - 1; k++) step();
        chk("holdoff_reach2", hold, HT - 1);
        bus.flap_req = 1'b1;
        step();
        chk("early_flap", bus.state, ST_OVER);
        bus.flap_req = 1'b0;
        step();
        to_idle();

        // Game scoring 7, then 4: best keeps the higher.
        to_play();
        pulse_score(7);
        collide();
        chk("g7_score", bus.score, 7);
        chk("best_g7", bus.best_score, BEST_ON ? 7 : 0);
        to_idle();
        to_play();
        pulse_score(4);
        collide();
        chk("g4_score", bus.score, 4);
        chk("best_g4", bus.best_score, BEST_ON ? 7 : 0);
        to_idle();

        // Saturation.
        to_play();
        pulse_score(17);
        chk("score_sat", bus.score, 15);
        chk("best_in_play", bus.best_score, BEST_ON ? 7 : 0);

        // Reset mid-game.
        rst = 1'b1;
        step();
        chk("midrst_state", bus.state, ST_IDLE);
        chk("midrst_score", bus.score, 0);
        chk("midrst_best", bus.best_score, 0);
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
